// File: rtl/csa_pipe_adder_pkg.sv
// rtl/csa_pipe_adder_pkg.sv - shared types and configuration helpers for the carry-skip pipeline
package csa_pipe_adder_pkg;

   localparam int CSA_DEF_WIDTH = 32;
   localparam int CSA_DEF_BLK   = 4;
   localparam int CSA_DEF_BPS   = 2;

   // Per-stage control record: beat valid plus the carry handed to the next stage.
   typedef struct packed {
      logic vld;
      logic c;
   } csa_stg_t;

   function automatic int csa_nstg(input int width, input int blk, input int bps);
      int nblk;
      nblk = width / blk;
      return (nblk + bps - 1) / bps;
   endfunction

   function automatic bit csa_cfg_ok(input int width, input int blk, input int bps);
      return (blk > 0) && (bps > 0) && (width >= blk) && ((width % blk) == 0);
   endfunction

endpackage

// File: rtl/csa_pipe_adder_if.sv
// rtl/csa_pipe_adder_if.sv - operand/result handshake bundle for csa_pipe_adder
interface csa_pipe_adder_if
   import csa_pipe_adder_pkg::*;
#(
   parameter int WIDTH = CSA_DEF_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );

endinterface

// File: rtl/csa_pipe_adder_blk.sv
// rtl/csa_pipe_adder_blk.sv - one combinational carry-skip block (ripple plus skip mux)
module csa_blk
   import csa_pipe_adder_pkg::*;
#(
   parameter int BLK = CSA_DEF_BLK
) (
   input  logic [BLK-1:0] a_i,
   input  logic [BLK-1:0] b_i,
   input  logic           ci_i,
   output logic [BLK-1:0] s_o,
   output logic           co_o,
   output logic           ci_msb_o
);

   logic [BLK-1:0] p;
   logic [BLK-1:0] g;
   logic [BLK:0]   c;

   always_comb begin
      p    = a_i ^ b_i;
      g    = a_i & b_i;
      c    = '0;
      c[0] = ci_i;
      for (int j = 0; j < BLK; j++) begin
         c[j+1] = g[j] | (p[j] & c[j]);
      end
   end

   assign s_o      = p ^ c[BLK-1:0];
   // When every bit propagates, the block carry-in bypasses the ripple chain.
   assign co_o     = (&p) ? ci_i : c[BLK];
   assign ci_msb_o = c[BLK-1];

endmodule

// File: rtl/csa_pipe_adder.sv
// rtl/csa_pipe_adder.sv - pipelined carry-skip adder/subtractor with valid/ready handshake
module csa_pipe_adder
   import csa_pipe_adder_pkg::*;
#(
   parameter int WIDTH = CSA_DEF_WIDTH,
   parameter int BLK   = CSA_DEF_BLK,
   parameter int BPS   = CSA_DEF_BPS
) (
   input  logic            clk,
   input  logic            rst_n,
   csa_pipe_adder_if.slave bus
);

   localparam int NBLK = WIDTH / BLK;
   localparam int NSTG = csa_nstg(WIDTH, BLK, BPS);

   if (!csa_cfg_ok(WIDTH, BLK, BPS)) begin : g_cfg_err
      $error("csa_pipe_adder: WIDTH must be a positive multiple of BLK, BPS must be positive");
   end

   function automatic logic [WIDTH-1:0] stage_mask(input int k);
      logic [WIDTH-1:0] m;
      m = '0;
      for (int j = 0; j < WIDTH; j++) begin
         if ((j / (BLK * BPS)) == k) m[j] = 1'b1;
      end
      return m;
   endfunction

   logic adv;

   // Stage inputs: stage 0 sees the port, stage k>0 sees the registers of stage k-1.
   logic [WIDTH-1:0] st_a [NSTG];
   logic [WIDTH-1:0] st_b [NSTG];
   logic [WIDTH-1:0] st_s [NSTG];
   logic             st_c [NSTG];
   logic             st_v [NSTG];

   logic [WIDTH-1:0] q_s [NSTG];
   logic             q_c [NSTG];
   logic             q_v [NSTG];

   logic [WIDTH-1:0] blk_sum;
   logic             top_cmsb;
   logic             last_cmsb;

   assign adv          = bus.out_ready | ~bus.out_valid;
   assign bus.in_ready = adv;

   for (genvar i = 0; i < NBLK; i++) begin : g_blk
      localparam int K = i / BPS;
      logic ci;
      logic co;

      if ((i % BPS) == 0) begin : g_ci_stage
         assign ci = st_c[K];
      end else begin : g_ci_chain
         assign ci = g_blk[i-1].co;
      end

      if (i == NBLK - 1) begin : g_top
         csa_blk #(.BLK(BLK)) u_blk (
            .a_i      (st_a[K][i*BLK +: BLK]),
            .b_i      (st_b[K][i*BLK +: BLK]),
            .ci_i     (ci),
            .s_o      (blk_sum[i*BLK +: BLK]),
            .co_o     (co),
            .ci_msb_o (top_cmsb)
         );
      end else begin : g_mid
         logic unused_cmsb;
         csa_blk #(.BLK(BLK)) u_blk (
            .a_i      (st_a[K][i*BLK +: BLK]),
            .b_i      (st_b[K][i*BLK +: BLK]),
            .ci_i     (ci),
            .s_o      (blk_sum[i*BLK +: BLK]),
            .co_o     (co),
            .ci_msb_o (unused_cmsb)
         );
      end
   end

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      localparam int B_END = (((k + 1) * BPS) < NBLK) ? ((k + 1) * BPS) : NBLK;
      localparam logic [WIDTH-1:0] MASK = stage_mask(k);

      logic [WIDTH-1:0] s_d;
      logic [WIDTH-1:0] s_q;
      csa_stg_t         ctl_d;
      csa_stg_t         ctl_q;

      if (k == 0) begin : g_head
         assign st_v[0] = bus.in_valid;
         assign st_a[0] = bus.a;
         assign st_b[0] = bus.sub ? ~bus.b : bus.b;
         assign st_s[0] = '0;
         assign st_c[0] = bus.sub ? 1'b1 : bus.cin;
      end else begin : g_body
         assign st_v[k] = q_v[k-1];
         assign st_c[k] = q_c[k-1];
         assign st_s[k] = q_s[k-1];
      end

      // Merge this stage's freshly computed blocks into the skewed partial sum.
      always_comb begin
         ctl_d.vld = st_v[k];
         ctl_d.c   = g_blk[B_END-1].co;
         s_d       = (st_s[k] & ~MASK) | (blk_sum & MASK);
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ctl_q <= '0;
            s_q   <= '0;
         end else if (adv) begin
            ctl_q.vld <= ctl_d.vld;
            if (ctl_d.vld) begin
               ctl_q.c <= ctl_d.c;
               s_q     <= s_d;
            end
         end
      end

      assign q_v[k] = ctl_q.vld;
      assign q_c[k] = ctl_q.c;
      assign q_s[k] = s_q;

      if (k < NSTG - 1) begin : g_fwd
         logic [WIDTH-1:0] a_q;
         logic [WIDTH-1:0] b_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv && st_v[k]) begin
               a_q <= st_a[k];
               b_q <= st_b[k];
            end
         end

         assign st_a[k+1] = a_q;
         assign st_b[k+1] = b_q;
      end

      if (k == NSTG - 1) begin : g_tail
         logic cmsb_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cmsb_q <= 1'b0;
            end else if (adv && st_v[k]) begin
               cmsb_q <= top_cmsb;
            end
         end

         assign last_cmsb = cmsb_q;
      end
   end

   assign bus.out_valid = q_v[NSTG-1];
   assign bus.sum       = q_s[NSTG-1];
   assign bus.cout      = q_c[NSTG-1];
   assign bus.ovf       = q_c[NSTG-1] ^ last_cmsb;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb/tb_csa_pipe_adder.sv - self-checking bench for csa_pipe_adder (32-bit/4-stage and 12-bit/1-stage)
module tb_csa_pipe_adder;

   localparam int LAT32 = 3;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   logic clk;
   logic rst_n;

   csa_pipe_adder_if #(.WIDTH(32)) i32 ();
   csa_pipe_adder_if #(.WIDTH(12)) i12 ();

   csa_pipe_adder #(.WIDTH(32), .BLK(4), .BPS(2)) u_dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (i32.slave)
   );

   csa_pipe_adder #(.WIDTH(12), .BLK(4), .BPS(3)) u_dut12 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (i12.slave)
   );

   int   total = 0;
   int   bad   = 0;
   int   rx32  = 0;
   int   stall_seen = 0;
   exp_t q32 [$];
   exp_t q12 [$];
   vec_t tbl [9];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_500_000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Plain arithmetic reference: {cout,sum} = a + b_eff + ce, overflow from operand/result signs.
   function automatic exp_t ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic sub);
      logic [63:0] m, aa, be, t;
      exp_t e;
      m      = (64'd1 << w) - 64'd1;
      aa     = {32'd0, a} & m;
      be     = sub ? (~{32'd0, b} & m) : ({32'd0, b} & m);
      t      = aa + be + {63'd0, (sub ? 1'b1 : cin)};
      e.sum  = t[31:0] & m[31:0];
      e.cout = t[w];
      e.ovf  = (aa[w-1] == be[w-1]) && (t[w-1] != aa[w-1]);
      return e;
   endfunction

   task automatic cyc32(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic ordy, output logic acc);
      exp_t e;
      i32.in_valid  = v;
      i32.a         = a;
      i32.b         = b;
      i32.cin       = cin;
      i32.sub       = sub;
      i32.out_ready = ordy;
      @(negedge clk);
      chk("rdy32", i32.in_ready, !i32.out_valid || ordy);
      if (i32.out_valid && !ordy) stall_seen++;
      if (i32.out_valid && ordy) begin
         if (q32.size() == 0) begin
            chk("spurious32", i32.out_valid, 1'b0);
         end else begin
            e = q32.pop_front();
            chk("sum32", i32.sum, e.sum);
            chk("cout32", i32.cout, e.cout);
            chk("ovf32", i32.ovf, e.ovf);
            rx32++;
         end
      end
      acc = v && i32.in_ready;
      if (acc) q32.push_back(ref_add(32, a, b, cin, sub));
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int n;
      bit seen;
      i32.in_valid  = 1'b1;
      i32.a         = v.a;
      i32.b         = v.b;
      i32.cin       = v.cin;
      i32.sub       = v.sub;
      i32.out_ready = 1'b1;
      @(negedge clk);
      chk({nm, "_rdy"}, i32.in_ready, 1'b1);
      @(posedge clk);
      #1;
      i32.in_valid = 1'b0;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         if (i32.out_valid) begin
            seen = 1'b1;
         end else begin
            n++;
            @(posedge clk);
            #1;
         end
      end
      chk({nm, "_seen"}, seen, 1'b1);
      if (seen) begin
         chk({nm, "_lat"}, n, LAT32);
         chk({nm, "_sum"}, i32.sum, v.sum);
         chk({nm, "_cout"}, i32.cout, v.cout);
         chk({nm, "_ovf"}, i32.ovf, v.ovf);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic        acc;
      logic        v, ordy, ci, sb;
      logic [31:0] ra, rb;
      logic [31:0] last12;
      exp_t        e;
      int          sent;
      int          c;

      tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
      tbl[5] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      tbl[6] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      tbl[7] = '{32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_000D, 1'b1, 1'b0};
      tbl[8] = '{32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 32'h9999_999A, 1'b0, 1'b0};

      rst_n = 1'b0;
      i32.in_valid = 1'b0; i32.a = '0; i32.b = '0; i32.cin = 1'b0; i32.sub = 1'b0; i32.out_ready = 1'b0;
      i12.in_valid = 1'b0; i12.a = '0; i12.b = '0; i12.cin = 1'b0; i12.sub = 1'b0; i12.out_ready = 1'b0;
      #2;
      chk("rst_valid32", i32.out_valid, 1'b0);
      chk("rst_sum32", i32.sum, 32'h0);
      chk("rst_cout32", i32.cout, 1'b0);
      chk("rst_ovf32", i32.ovf, 1'b0);
      chk("rst_rdy32", i32.in_ready, 1'b1);
      chk("rst_valid12", i12.out_valid, 1'b0);
      chk("rst_sum12", i12.sum, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_vec(tbl[i], $sformatf("vec%0d", i));
      end

      // Six back-to-back beats with a three-cycle output stall in the middle.
      rx32 = 0;
      stall_seen = 0;
      sent = 0;
      c = 0;
      while ((sent < 6 || q32.size() != 0) && c < 60) begin
         ra = $urandom;
         rb = $urandom;
         ci = 1'($urandom_range(1));
         sb = 1'($urandom_range(1));
         cyc32(sent < 6, ra, rb, ci, sb, !(c >= 5 && c < 8), acc);
         if (acc) sent++;
         c++;
      end
      chk("stream_rx", rx32, 6);
      chk("stream_stall", stall_seen > 0, 1'b1);
      chk("stream_left", q32.size(), 0);

      // Reset while beats are in flight: nothing stale may come out afterwards.
      for (int i = 0; i < 3; i++) begin
         cyc32(1'b1, $urandom | 32'h1, $urandom, 1'b0, 1'b0, 1'b1, acc);
      end
      cyc32(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
      cyc32(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
      chk("pre_rst_valid", i32.out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", i32.out_valid, 1'b0);
      chk("mid_rst_sum", i32.sum, 32'h0);
      chk("mid_rst_rdy", i32.in_ready, 1'b1);
      q32.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc32(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
         chk("post_rst_idle", i32.out_valid, 1'b0);
      end
      run_vec(tbl[2], "post_rst");

      // Single-stage configuration under random traffic and random back-pressure.
      i32.in_valid = 1'b0;
      last12 = 32'h0;
      for (int n = 0; n < 10000; n++) begin
         v    = ($urandom_range(3) != 0);
         ordy = ($urandom_range(3) != 0);
         ra   = $urandom;
         rb   = $urandom;
         ci   = 1'($urandom_range(1));
         sb   = 1'($urandom_range(1));
         i12.in_valid  = v;
         i12.a         = ra[11:0];
         i12.b         = rb[11:0];
         i12.cin       = ci;
         i12.sub       = sb;
         i12.out_ready = ordy;
         @(negedge clk);
         chk("v12_valid", i12.out_valid, q12.size() != 0);
         chk("v12_rdy", i12.in_ready, !i12.out_valid || ordy);
         if (!i12.out_valid) chk("v12_hold", i12.sum, last12);
         if (i12.out_valid && ordy && q12.size() != 0) begin
            e = q12.pop_front();
            chk("v12_sum", i12.sum, e.sum);
            chk("v12_cout", i12.cout, e.cout);
            chk("v12_ovf", i12.ovf, e.ovf);
            last12 = e.sum;
         end
         if (v && i12.in_ready) q12.push_back(ref_add(12, ra, rb, ci, sb));
         @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
